// File: rtl/calculator_core.sv
// Multi-cycle integer calculator: single-cycle ADD/SUB, iterative shift-add MUL
// and restoring DIV, each finishing with a one-cycle DONE pulse.
module calculator_core #(
    parameter int WIDTH = 4
) (
    input  logic               clk_clk,
    input  logic               reset_reset,
    input  logic [WIDTH-1:0]   operand_a,
    input  logic [WIDTH-1:0]   operand_b,
    input  logic [1:0]         op_sel,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic [WIDTH-1:0]   remainder,
    output logic               negative,
    output logic               error
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } state_t;

    state_t               state_reg, state_next;
    logic [2*WIDTH-1:0]   work_a_reg, work_a_next;
    logic [WIDTH-1:0]     work_b_reg, work_b_next;
    logic [2*WIDTH-1:0]   acc_reg, acc_next;
    logic [CW-1:0]        cnt_reg, cnt_next;
    logic [2*WIDTH-1:0]   result_reg, result_next;
    logic [WIDTH-1:0]     remainder_reg, remainder_next;
    logic                 negative_reg, negative_next;
    logic                 error_reg, error_next;

    logic [2*WIDTH-1:0]   mul_sum;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_rem;
    logic                 div_ge;
    logic [WIDTH-1:0]     div_quot;
    logic                 last_step;

    always_comb begin
        // MUL: work_a holds the shifting multiplicand, work_b the shifting multiplier.
        mul_sum   = acc_reg + (work_b_reg[0] ? work_a_reg : '0);
        // DIV: acc holds the partial remainder, work_a shifts dividend out / quotient in.
        div_shift = {acc_reg[WIDTH-1:0], work_a_reg[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, work_b_reg});
        div_rem   = div_ge ? (div_shift - {1'b0, work_b_reg}) : div_shift;
        div_quot  = {work_a_reg[WIDTH-2:0], div_ge};
        last_step = (cnt_reg == CW'(WIDTH - 1));
    end

    always_comb begin
        state_next     = state_reg;
        work_a_next    = work_a_reg;
        work_b_next    = work_b_reg;
        acc_next       = acc_reg;
        cnt_next       = cnt_reg;
        result_next    = result_reg;
        remainder_next = remainder_reg;
        negative_next  = negative_reg;
        error_next     = error_reg;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    work_a_next = (2*WIDTH)'(operand_a);
                    work_b_next = operand_b;
                    acc_next    = '0;
                    cnt_next    = '0;
                    case (op_sel)
                        2'b00: begin
                            result_next    = (2*WIDTH)'(operand_a) + (2*WIDTH)'(operand_b);
                            remainder_next = '0;
                            negative_next  = 1'b0;
                            error_next     = 1'b0;
                            state_next     = ST_DONE;
                        end
                        2'b01: begin
                            result_next    = (2*WIDTH)'(operand_a) - (2*WIDTH)'(operand_b);
                            remainder_next = '0;
                            negative_next  = (operand_a < operand_b);
                            error_next     = 1'b0;
                            state_next     = ST_DONE;
                        end
                        2'b10: begin
                            state_next = ST_MUL;
                        end
                        default: begin
                            if (operand_b == '0) begin
                                result_next    = '1;
                                remainder_next = operand_a;
                                negative_next  = 1'b0;
                                error_next     = 1'b1;
                                state_next     = ST_DONE;
                            end else begin
                                state_next = ST_DIV;
                            end
                        end
                    endcase
                end
            end
            ST_MUL: begin
                acc_next    = mul_sum;
                work_a_next = work_a_reg << 1;
                work_b_next = work_b_reg >> 1;
                cnt_next    = cnt_reg + CW'(1);
                if (last_step) begin
                    result_next    = mul_sum;
                    remainder_next = '0;
                    negative_next  = 1'b0;
                    error_next     = 1'b0;
                    state_next     = ST_DONE;
                end
            end
            ST_DIV: begin
                acc_next    = (2*WIDTH)'(div_rem);
                work_a_next = (2*WIDTH)'(div_quot);
                cnt_next    = cnt_reg + CW'(1);
                if (last_step) begin
                    result_next    = (2*WIDTH)'(div_quot);
                    remainder_next = div_rem[WIDTH-1:0];
                    negative_next  = 1'b0;
                    error_next     = 1'b0;
                    state_next     = ST_DONE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_reg     <= ST_IDLE;
            work_a_reg    <= '0;
            work_b_reg    <= '0;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            result_reg    <= '0;
            remainder_reg <= '0;
            negative_reg  <= 1'b0;
            error_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            work_a_reg    <= work_a_next;
            work_b_reg    <= work_b_next;
            acc_reg       <= acc_next;
            cnt_reg       <= cnt_next;
            result_reg    <= result_next;
            remainder_reg <= remainder_next;
            negative_reg  <= negative_next;
            error_reg     <= error_next;
        end
    end

    assign busy      = (state_reg == ST_MUL) || (state_reg == ST_DIV);
    assign done      = (state_reg == ST_DONE);
    assign result    = result_reg;
    assign remainder = remainder_reg;
    assign negative  = negative_reg;
    assign error     = error_reg;

endmodule
